clock_set_ctrl: RTL and testbench

Timekeeping and time-set controller for the digital clock display. Holds the hour, minute and second BCD registers and advances them on a 1 Hz tick. A two-key mode/increment state machine sets the time. Drives the six BCD digit inputs of the scan/display datapath, blanking the field being edited at the blink rate.

---
 rtl/clock_set_ctrl_if.sv | 26 ++
 rtl/clock_set_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Key/tick inputs and display outputs of the time-set controller.
// The master side drives the keys and ticks; the slave side is the controller.
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       blink_tick;
  logic       key_mode;
  logic       key_inc;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;
  logic [3:0] bcd4;
  logic [3:0] bcd5;
  logic [1:0] mode;
  logic       day_pulse;

  modport master (
    output tick_1hz, blink_tick, key_mode, key_inc,
    input  bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, mode, day_pulse
  );

  modport slave (
    input  tick_1hz, blink_tick, key_mode, key_inc,
    output bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, mode, day_pulse
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Timekeeping and two-key time-set controller: BCD hh:mm:ss registers advanced
// on a 1 Hz tick, set via mode/inc keys, selected field blinked while editing.
module clock_set_ctrl #(
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input logic             clk,
  input logic             cr,
  clock_set_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] sec_u, sec_t, min_u, min_t, hr_u, hr_t;
  logic       blink_phase;
  logic       day_pulse_q;
  logic       key_mode_q;
  logic       key_inc_q;

  logic mode_press;
  logic inc_press;
  logic sec_wrap;
  logic min_wrap;
  logic hr_wrap;
  logic blank_h, blank_m, blank_s;

  // A same-cycle mode press swallows the increment.
  assign mode_press = io.key_mode & ~key_mode_q;
  assign inc_press  = io.key_inc & ~key_inc_q & ~mode_press;

  assign sec_wrap = (sec_t == 4'd5) && (sec_u == 4'd9);
  assign min_wrap = (min_t == 4'd5) && (min_u == 4'd9);
  assign hr_wrap  = (hr_t  == 4'd2) && (hr_u  == 4'd3);

  always_comb begin
    next_state = RUN;
    unique case (state)
      RUN:     next_state = SET_H;
      SET_H:   next_state = SET_M;
      SET_M:   next_state = SET_S;
      SET_S:   next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge cr) begin
    if (cr) begin
      state       <= RUN;
      sec_u       <= '0;
      sec_t       <= '0;
      min_u       <= '0;
      min_t       <= '0;
      hr_u        <= '0;
      hr_t        <= '0;
      blink_phase <= 1'b0;
      day_pulse_q <= 1'b0;
      key_mode_q  <= 1'b1;
      key_inc_q   <= 1'b1;
    end else begin
      key_mode_q  <= io.key_mode;
      key_inc_q   <= io.key_inc;
      day_pulse_q <= 1'b0;

      if (mode_press || inc_press)
        blink_phase <= 1'b0;
      else if (io.blink_tick)
        blink_phase <= ~blink_phase;

      if (mode_press)
        state <= next_state;

      // Dispatch on the current state, so a tick on the press leaving SET_S is dropped.
      unique case (state)
        RUN: begin
          if (io.tick_1hz) begin
            if (sec_wrap) begin
              sec_u <= '0;
              sec_t <= '0;
              if (min_wrap) begin
                min_u <= '0;
                min_t <= '0;
                if (hr_wrap) begin
                  hr_u        <= '0;
                  hr_t        <= '0;
                  day_pulse_q <= 1'b1;
                end else if (hr_u == 4'd9) begin
                  hr_u <= '0;
                  hr_t <= hr_t + 4'd1;
                end else begin
                  hr_u <= hr_u + 4'd1;
                end
              end else if (min_u == 4'd9) begin
                min_u <= '0;
                min_t <= min_t + 4'd1;
              end else begin
                min_u <= min_u + 4'd1;
              end
            end else if (sec_u == 4'd9) begin
              sec_u <= '0;
              sec_t <= sec_t + 4'd1;
            end else begin
              sec_u <= sec_u + 4'd1;
            end
          end
        end
        SET_H: begin
          if (inc_press) begin
            if (hr_wrap) begin
              hr_u <= '0;
              hr_t <= '0;
            end else if (hr_u == 4'd9) begin
              hr_u <= '0;
              hr_t <= hr_t + 4'd1;
            end else begin
              hr_u <= hr_u + 4'd1;
            end
          end
        end
        SET_M: begin
          if (inc_press) begin
            if (min_wrap) begin
              min_u <= '0;
              min_t <= '0;
            end else if (min_u == 4'd9) begin
              min_u <= '0;
              min_t <= min_t + 4'd1;
            end else begin
              min_u <= min_u + 4'd1;
            end
          end
        end
        SET_S: begin
          if (inc_press) begin
            sec_u <= '0;
            sec_t <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign blank_h = blink_phase && (state == SET_H);
  assign blank_m = blink_phase && (state == SET_M);
  assign blank_s = blink_phase && (state == SET_S);

  always_comb begin
    io.bcd0 = blank_s ? BLANK_CODE : sec_u;
    io.bcd1 = blank_s ? BLANK_CODE : sec_t;
    io.bcd2 = blank_m ? BLANK_CODE : min_u;
    io.bcd3 = blank_m ? BLANK_CODE : min_t;
    io.bcd4 = blank_h ? BLANK_CODE : hr_u;
    io.bcd5 = blank_h ? BLANK_CODE : hr_t;
  end

  assign io.mode      = state;
  assign io.day_pulse = day_pulse_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: reset, rollover, field setting, blinking,
// simultaneous key events and mid-edit reset.
module tb_clock_set_ctrl;

  logic clk;
  logic cr;
  int   checks;
  int   errors;

  clock_set_ctrl_if io ();

  clock_set_ctrl #(.BLANK_CODE(4'hF)) dut (
    .clk (clk),
    .cr  (cr),
    .io  (io.slave)
  );

  logic [23:0] shown;
  assign shown = {io.bcd5, io.bcd4, io.bcd3, io.bcd2, io.bcd1, io.bcd0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    io.key_mode = 1'b1;
    step();
    io.key_mode = 1'b0;
    step();
  endtask

  task automatic press_inc();
    io.key_inc = 1'b1;
    step();
    io.key_inc = 1'b0;
    step();
  endtask

  task automatic pulse_tick();
    io.tick_1hz = 1'b1;
    step();
    io.tick_1hz = 1'b0;
  endtask

  task automatic pulse_blink();
    io.blink_tick = 1'b1;
    step();
    io.blink_tick = 1'b0;
  endtask

  task automatic test_reset();
    cr = 1'b1;
    io.key_mode = 1'b1;
    repeat (2) step();
    checks++;
    if (shown !== 24'h000000) begin
      errors++; $display("FAIL reset_time: got %h want 000000", shown);
    end
    checks++;
    if (io.mode !== 2'd0 || io.day_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_mode: got mode %0d day %b want 0 0", io.mode, io.day_pulse);
    end
    cr = 1'b0;
    repeat (3) step();
    checks++;
    if (io.mode !== 2'd0) begin
      errors++; $display("FAIL held_key_no_press: got mode %0d want 0", io.mode);
    end
    io.key_mode = 1'b0;
    step();
    io.key_mode = 1'b1;
    step();
    checks++;
    if (io.mode !== 2'd1) begin
      errors++; $display("FAIL repress_after_reset: got mode %0d want 1", io.mode);
    end
    io.key_mode = 1'b0;
    step();
    repeat (3) press_mode();
    checks++;
    if (io.mode !== 2'd0) begin
      errors++; $display("FAIL mode_cycle_back: got mode %0d want 0", io.mode);
    end
  endtask

  task automatic test_rollover();
    press_mode();
    repeat (23) press_inc();
    checks++;
    if (shown !== 24'h230000 || io.mode !== 2'd1) begin
      errors++; $display("FAIL preload_hours: got %h mode %0d want 230000 mode 1", shown, io.mode);
    end
    press_mode();
    repeat (59) press_inc();
    press_mode();
    press_mode();
    repeat (58) pulse_tick();
    checks++;
    if (shown !== 24'h235958 || io.mode !== 2'd0) begin
      errors++; $display("FAIL preload_full: got %h mode %0d want 235958 mode 0", shown, io.mode);
    end
    pulse_tick();
    checks++;
    if (shown !== 24'h235959 || io.day_pulse !== 1'b0) begin
      errors++; $display("FAIL tick_235959: got %h day %b want 235959 0", shown, io.day_pulse);
    end
    pulse_tick();
    checks++;
    if (shown !== 24'h000000 || io.day_pulse !== 1'b1) begin
      errors++; $display("FAIL day_rollover: got %h day %b want 000000 1", shown, io.day_pulse);
    end
    step();
    checks++;
    if (io.day_pulse !== 1'b0) begin
      errors++; $display("FAIL day_pulse_width: got %b want 0", io.day_pulse);
    end
  endtask

  task automatic test_set_hours();
    repeat (37) pulse_tick();
    checks++;
    if (shown !== 24'h000037) begin
      errors++; $display("FAIL run_count_37: got %h want 000037", shown);
    end
    press_mode();
    repeat (22) press_inc();
    checks++;
    if (shown !== 24'h220037) begin
      errors++; $display("FAIL set_h_22: got %h want 220037", shown);
    end
    press_inc();
    checks++;
    if (shown !== 24'h230037) begin
      errors++; $display("FAIL set_h_23: got %h want 230037", shown);
    end
    press_inc();
    checks++;
    if (shown !== 24'h000037) begin
      errors++; $display("FAIL set_h_wrap: got %h want 000037", shown);
    end
    press_inc();
    checks++;
    if (shown !== 24'h010037) begin
      errors++; $display("FAIL set_h_01: got %h want 010037", shown);
    end
    pulse_tick();
    step();
    checks++;
    if (shown !== 24'h010037) begin
      errors++; $display("FAIL set_h_frozen: got %h want 010037", shown);
    end
  endtask

  task automatic test_set_min_sec();
    press_mode();
    repeat (59) press_inc();
    checks++;
    if (shown !== 24'h015937 || io.mode !== 2'd2) begin
      errors++; $display("FAIL set_m_59: got %h mode %0d want 015937 mode 2", shown, io.mode);
    end
    press_inc();
    checks++;
    if (shown !== 24'h010037) begin
      errors++; $display("FAIL set_m_no_carry: got %h want 010037", shown);
    end
    press_mode();
    press_inc();
    checks++;
    if (shown !== 24'h010000 || io.mode !== 2'd3) begin
      errors++; $display("FAIL set_s_clear: got %h mode %0d want 010000 mode 3", shown, io.mode);
    end
    io.key_mode = 1'b1;
    io.tick_1hz = 1'b1;
    step();
    io.key_mode = 1'b0;
    io.tick_1hz = 1'b0;
    step();
    checks++;
    if (shown !== 24'h010000 || io.mode !== 2'd0) begin
      errors++; $display("FAIL enter_run_tick_dropped: got %h mode %0d want 010000 mode 0", shown, io.mode);
    end
    pulse_tick();
    checks++;
    if (shown !== 24'h010001) begin
      errors++; $display("FAIL run_resume: got %h want 010001", shown);
    end
  endtask

  task automatic test_blink();
    pulse_blink();
    checks++;
    if (shown !== 24'h010001) begin
      errors++; $display("FAIL run_no_blank: got %h want 010001", shown);
    end
    press_mode();
    press_mode();
    checks++;
    if (shown !== 24'h010001 || io.mode !== 2'd2) begin
      errors++; $display("FAIL set_m_visible: got %h mode %0d want 010001 mode 2", shown, io.mode);
    end
    pulse_blink();
    checks++;
    if (shown !== 24'h01FF01) begin
      errors++; $display("FAIL set_m_blank: got %h want 01ff01", shown);
    end
    io.key_inc = 1'b1;
    io.blink_tick = 1'b1;
    step();
    io.key_inc = 1'b0;
    io.blink_tick = 1'b0;
    checks++;
    if (shown !== 24'h010101) begin
      errors++; $display("FAIL inc_forces_visible: got %h want 010101", shown);
    end
    pulse_blink();
    checks++;
    if (shown !== 24'h01FF01) begin
      errors++; $display("FAIL set_m_reblank: got %h want 01ff01", shown);
    end
  endtask

  task automatic test_simultaneous();
    press_mode();
    press_mode();
    press_mode();
    checks++;
    if (io.mode !== 2'd1 || shown !== 24'h010101) begin
      errors++; $display("FAIL reach_set_h: got %h mode %0d want 010101 mode 1", shown, io.mode);
    end
    io.key_mode = 1'b1;
    io.key_inc = 1'b1;
    step();
    io.key_mode = 1'b0;
    io.key_inc = 1'b0;
    step();
    checks++;
    if (io.mode !== 2'd2 || shown !== 24'h010101) begin
      errors++; $display("FAIL mode_inc_same_cycle: got %h mode %0d want 010101 mode 2", shown, io.mode);
    end
  endtask

  task automatic test_reset_mid_edit();
    press_mode();
    pulse_blink();
    checks++;
    if (io.mode !== 2'd3 || shown !== 24'h0101FF) begin
      errors++; $display("FAIL set_s_blank: got %h mode %0d want 0101ff mode 3", shown, io.mode);
    end
    io.key_inc = 1'b1;
    #2;
    cr = 1'b1;
    #1;
    checks++;
    if (shown !== 24'h000000 || io.mode !== 2'd0 || io.day_pulse !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h mode %0d day %b want 000000 mode 0 day 0", shown, io.mode, io.day_pulse);
    end
    step();
    io.key_inc = 1'b0;
    cr = 1'b0;
    repeat (2) step();
    checks++;
    if (shown !== 24'h000000 || io.mode !== 2'd0) begin
      errors++; $display("FAIL after_reset_release: got %h mode %0d want 000000 mode 0", shown, io.mode);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cr            = 1'b1;
    io.tick_1hz   = 1'b0;
    io.blink_tick = 1'b0;
    io.key_mode   = 1'b0;
    io.key_inc    = 1'b0;
    test_reset();
    test_rollover();
    test_set_hours();
    test_set_min_sec();
    test_blink();
    test_simultaneous();
    test_reset_mid_edit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
